regfile_access_controller: RTL and testbench
============================================

// Module: regfile_access_controller
// PURPOSE
// - Command-driven initiator for the 8-entry register file: accepts one op per handshake, drives its
//   source selects, captures Out_0/Out_1, computes the result and issues a single-cycle write-back.
// - Sits between a test/sequencer front end and the register file; owns every register file control input.
// PARAMETERS
// - W  4  data width; must match the register file W
// PORTS
// - CLK                    in   1  clock, rising edge
// - Reset                  in   1  asynchronous, active-high reset
// - Cmd_Valid              in   1  command present
// - Cmd_Ready              out  1  controller idle, can accept a command
// - Cmd_Op                 in   2  00 LOAD imm, 01 MOVE src0, 10 ADD src0+src1, 11 SUB src0-src1
// - Cmd_Dest               in   3  destination register
// - Cmd_Src0, Cmd_Src1     in   3  source registers
// - Cmd_Imm                in   W  immediate for LOAD
// - RF_Source_Select_0/1   out  3  to register file read ports
// - RF_Out_0, RF_Out_1     in   W  from register file, combinational read
// - RF_Destination_Select  out  3  to register file write address
// - RF_Write_Enable        out  1  to register file write enable
// - RF_Data                out  W  to register file write data
// - Result                 out  W  last value written back
// - Done                   out  1  one-cycle pulse, coincident with write-back
// BEHAVIOUR
// - Reset is async. All outputs are 0 and the state is IDLE, except Cmd_Ready, which is 1.
// - FSM: IDLE -> READ -> EXEC -> WRITE -> IDLE. There is no other path; all ops take the same latency.
// - IDLE: Cmd_Ready=1. On Cmd_Valid&&Cmd_Ready at edge k, latch Op/Dest/Src0/Src1/Imm and go to READ.
// - READ (cycle k+1): Cmd_Ready=0. RF_Source_Select_0/1 come from the latched Src0/Src1.
//   Capture RF_Out_0/1 into operand registers at the end of the cycle.
// - EXEC (cycle k+2): compute from the captured operands into a result register.
//   LOAD=Imm, MOVE=A, ADD=(A+B) mod 2^W, SUB=(A-B) mod 2^W.
// - WRITE (cycle k+3): RF_Write_Enable=1, RF_Destination_Select=Dest, RF_Data=result, Done=1.
//   Result updates at the end of the cycle.
// - Cycle k+4: IDLE, Cmd_Ready=1. Back-to-back throughput is one command per 4 cycles.
// - RF_Write_Enable and Done are high only in WRITE. Each accepted command produces exactly one write.
// - Source selects hold the latched values in every state; they read 0 after reset.
//   RF_Data and RF_Destination_Select hold their values outside WRITE.
// - Dest equal to Src0 or Src1 is legal: operands are captured in READ, so the old value is used.
// - Cmd_Valid while busy is ignored and nothing is latched; the requester must hold it until Cmd_Ready.
// - Src0 equal to Src1 is legal, e.g. SUB r,r,r writes 0.
// - Reset mid-operation, in any state, aborts the command. Write_Enable drops immediately and
//   no write is issued; state returns to IDLE.
// CONFIGURATION
// - REGFILE_CTRL_FLAGS_EN defined: adds outputs Flag_Carry (1) and Flag_Zero (1), registered in WRITE.
//   - Carry is the ADD carry-out or the SUB borrow (A<B unsigned); it is 0 for LOAD and MOVE.
//   - Zero is (result==0). Both reset to 0 and hold until the next WRITE.
// - REGFILE_CTRL_FLAGS_EN undefined: the flag ports and logic are absent; all other behaviour is identical.
// TESTING (W=4, paired with the real register file)
// - LOAD r3=4'hA, then MOVE r5<-r3 -> the MOVE write-back has RF_Data=4'hA, Dest=5, Done at k+3; Result=4'hA.
// - r1=7, r2=12, ADD r0=r1+r2 -> RF_Data=4'h3 (19 mod 16); with FLAGS_EN, Carry=1, Zero=0.
// - r1=3, r2=5, SUB r4=r1-r2 -> RF_Data=4'hE; with FLAGS_EN, Carry(borrow)=1.
//   SUB r6=r2-r2 -> 0, Zero=1.
// - ADD r1=r1+r1 with r1=6 -> writes 12, because the old operand was used.
//   Second Cmd_Valid during READ/EXEC -> not accepted, Cmd_Ready=0.
// - Assert Reset during EXEC of LOAD r7=4'hF -> no Write_Enable pulse, r7 unchanged,
//   Cmd_Ready=1 after release.
// - Hold Cmd_Valid high with 4 queued commands -> accepts at cycles 0,4,8,12, exactly 4 Done pulses.

Source files
------------

// File: rtl/regfile_access_controller_if.sv
// regfile_access_controller_if: command handshake and register file bus for regfile_access_controller.
// Flag signals exist only when REGFILE_CTRL_FLAGS_EN is defined.
interface regfile_access_controller_if #(parameter int W = 4);
    logic         Cmd_Valid;
    logic         Cmd_Ready;
    logic [1:0]   Cmd_Op;
    logic [2:0]   Cmd_Dest;
    logic [2:0]   Cmd_Src0;
    logic [2:0]   Cmd_Src1;
    logic [W-1:0] Cmd_Imm;
    logic [2:0]   RF_Source_Select_0;
    logic [2:0]   RF_Source_Select_1;
    logic [W-1:0] RF_Out_0;
    logic [W-1:0] RF_Out_1;
    logic [2:0]   RF_Destination_Select;
    logic         RF_Write_Enable;
    logic [W-1:0] RF_Data;
    logic [W-1:0] Result;
    logic         Done;
`ifdef REGFILE_CTRL_FLAGS_EN
    logic         Flag_Carry;
    logic         Flag_Zero;
`endif
    modport master (
        output Cmd_Valid, Cmd_Op, Cmd_Dest, Cmd_Src0, Cmd_Src1, Cmd_Imm, RF_Out_0, RF_Out_1,
        input  Cmd_Ready, RF_Source_Select_0, RF_Source_Select_1, RF_Destination_Select,
               RF_Write_Enable, RF_Data, Result, Done
`ifdef REGFILE_CTRL_FLAGS_EN
        , input Flag_Carry, Flag_Zero
`endif
    );
    modport slave (
        input  Cmd_Valid, Cmd_Op, Cmd_Dest, Cmd_Src0, Cmd_Src1, Cmd_Imm, RF_Out_0, RF_Out_1,
        output Cmd_Ready, RF_Source_Select_0, RF_Source_Select_1, RF_Destination_Select,
               RF_Write_Enable, RF_Data, Result, Done
`ifdef REGFILE_CTRL_FLAGS_EN
        , output Flag_Carry, Flag_Zero
`endif
    );
endinterface

// File: rtl/regfile_access_controller.sv
// regfile_access_controller: 4-cycle IDLE/READ/EXEC/WRITE initiator driving an 8-entry register file.
// Define REGFILE_CTRL_FLAGS_EN to add registered Flag_Carry/Flag_Zero outputs.
module regfile_access_controller #(
    parameter int W = 4
) (
    input logic CLK,
    input logic Reset,
    regfile_access_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
    localparam logic [1:0] OP_MOVE = 2'd1, OP_ADD = 2'd2, OP_SUB = 2'd3;
    state_t state_q, state_d;
    logic         ready_q, ready_d, we_q, we_d, done_q, done_d;
    logic [1:0]   op_q, op_d;
    logic [2:0]   dest_q, dest_d, src0_q, src0_d, src1_q, src1_d, wdest_q, wdest_d;
    logic [W-1:0] imm_q, imm_d, a_q, a_d, b_q, b_d, data_q, data_d, result_q, result_d, alu;
`ifdef REGFILE_CTRL_FLAGS_EN
    logic cy_q, cy_d, fc_q, fc_d, fz_q, fz_d;
`endif
    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        we_d     = we_q;
        done_d   = done_q;
        op_d     = op_q;
        dest_d   = dest_q;
        src0_d   = src0_q;
        src1_d   = src1_q;
        imm_d    = imm_q;
        a_d      = a_q;
        b_d      = b_q;
        wdest_d  = wdest_q;
        data_d   = data_q;
        result_d = result_q;
`ifdef REGFILE_CTRL_FLAGS_EN
        cy_d     = cy_q;
        fc_d     = fc_q;
        fz_d     = fz_q;
`endif
        alu = op_q == OP_ADD ? a_q + b_q : op_q == OP_SUB ? a_q - b_q : op_q == OP_MOVE ? a_q : imm_q;
        case (state_q)
            IDLE: if (bus.Cmd_Valid && ready_q) begin
                op_d    = bus.Cmd_Op;
                dest_d  = bus.Cmd_Dest;
                src0_d  = bus.Cmd_Src0;
                src1_d  = bus.Cmd_Src1;
                imm_d   = bus.Cmd_Imm;
                ready_d = 1'b0;
                state_d = READ;
            end
            READ: begin
                a_d     = bus.RF_Out_0;
                b_d     = bus.RF_Out_1;
                state_d = EXEC;
            end
            EXEC: begin
                data_d  = alu;
                wdest_d = dest_q;
                we_d    = 1'b1;
                done_d  = 1'b1;
                state_d = WRITE;
`ifdef REGFILE_CTRL_FLAGS_EN
                // a wrapped sum is smaller than either addend exactly when the add overflowed
                cy_d    = op_q == OP_ADD ? alu < a_q : op_q == OP_SUB ? a_q < b_q : 1'b0;
`endif
            end
            WRITE: begin
                we_d     = 1'b0;
                done_d   = 1'b0;
                ready_d  = 1'b1;
                result_d = data_q;
                state_d  = IDLE;
`ifdef REGFILE_CTRL_FLAGS_EN
                fc_d     = cy_q;
                fz_d     = data_q == '0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            op_q     <= '0;
            dest_q   <= '0;
            src0_q   <= '0;
            src1_q   <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            wdest_q  <= '0;
            data_q   <= '0;
            result_q <= '0;
`ifdef REGFILE_CTRL_FLAGS_EN
            cy_q     <= 1'b0;
            fc_q     <= 1'b0;
            fz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            we_q     <= we_d;
            done_q   <= done_d;
            op_q     <= op_d;
            dest_q   <= dest_d;
            src0_q   <= src0_d;
            src1_q   <= src1_d;
            imm_q    <= imm_d;
            a_q      <= a_d;
            b_q      <= b_d;
            wdest_q  <= wdest_d;
            data_q   <= data_d;
            result_q <= result_d;
`ifdef REGFILE_CTRL_FLAGS_EN
            cy_q     <= cy_d;
            fc_q     <= fc_d;
            fz_q     <= fz_d;
`endif
        end
    end
    assign bus.Cmd_Ready             = ready_q;
    assign bus.RF_Source_Select_0    = src0_q;
    assign bus.RF_Source_Select_1    = src1_q;
    assign bus.RF_Destination_Select = wdest_q;
    assign bus.RF_Write_Enable       = we_q;
    assign bus.RF_Data               = data_q;
    assign bus.Result                = result_q;
    assign bus.Done                  = done_q;
`ifdef REGFILE_CTRL_FLAGS_EN
    assign bus.Flag_Carry            = fc_q;
    assign bus.Flag_Zero             = fz_q;
`endif
endmodule

// File: tb/tb_regfile_access_controller.sv
// tb_regfile_access_controller: scoreboard bench with a behavioural register file and reference model.
module tb_regfile_access_controller;
    localparam int W = 4;
    logic CLK = 1'b0;
    logic Reset = 1'b1;
    always #5 CLK = ~CLK;
    regfile_access_controller_if #(.W(W)) bus();
    regfile_access_controller #(.W(W)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));
    logic [W-1:0] rf [8] = '{default: '0};
    assign bus.RF_Out_0 = rf[bus.RF_Source_Select_0];
    assign bus.RF_Out_1 = rf[bus.RF_Source_Select_1];
    always @(posedge CLK) if (bus.RF_Write_Enable) rf[bus.RF_Destination_Select] <= bus.RF_Data;
    typedef struct {logic [2:0] dest; logic [W-1:0] data; bit c; bit z; int acc;} exp_t;
    exp_t q[$];
    int mdl [8];
    int errors = 0, checks = 0, cyc = 0, done_cnt = 0;
    always @(posedge CLK) cyc <= cyc + 1;
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask
    task automatic issue(input logic [1:0] op, input logic [2:0] d, s0, s1, input logic [W-1:0] imm,
                         input bit push, output int acc);
        int n, a, b, r;
        bit c;
        n = 0;
        bus.Cmd_Valid = 1'b1;
        bus.Cmd_Op = op;
        bus.Cmd_Dest = d;
        bus.Cmd_Src0 = s0;
        bus.Cmd_Src1 = s1;
        bus.Cmd_Imm = imm;
        while (!bus.Cmd_Ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) check("accept_timeout", n, 0);
        @(posedge CLK);
        a = mdl[s0];
        b = mdl[s1];
        c = 1'b0;
        if (op == 2'd0) r = int'(imm);
        else if (op == 2'd1) r = a;
        else if (op == 2'd2) begin r = (a + b) % 16; c = (a + b) > 15; end
        else begin r = (a - b + 16) % 16; c = a < b; end
        @(negedge CLK);
        acc = cyc;
        check("busy_ready", bus.Cmd_Ready, 0);
        if (push) begin
            mdl[d] = r;
            q.push_back('{dest: d, data: r[W-1:0], c: c, z: r == 0, acc: acc});
        end
    endtask
    task automatic idle(input int g);
        bus.Cmd_Valid = 1'b0;
        repeat (g) @(negedge CLK);
    endtask
    exp_t e;
    bit pend = 0;
    always @(negedge CLK) begin
        if (Reset) pend = 0;
        else begin
            if (pend) begin
                check("result", bus.Result, e.data);
`ifdef REGFILE_CTRL_FLAGS_EN
                check("flag_carry", bus.Flag_Carry, e.c);
                check("flag_zero", bus.Flag_Zero, e.z);
`endif
                pend = 0;
            end
            if (bus.RF_Write_Enable || bus.Done) begin
                done_cnt++;
                if (q.size() == 0) check("unexpected_write", 1, 0);
                else begin
                    e = q.pop_front();
                    check("we", bus.RF_Write_Enable, 1);
                    check("done", bus.Done, 1);
                    check("dest", bus.RF_Destination_Select, e.dest);
                    check("data", bus.RF_Data, e.data);
                    check("latency", cyc - e.acc, 2);
                    pend = 1;
                end
            end
        end
    end
    initial begin
        int acc, prev, d0;
        bus.Cmd_Valid = 1'b0;
        bus.Cmd_Op = '0;
        bus.Cmd_Dest = '0;
        bus.Cmd_Src0 = '0;
        bus.Cmd_Src1 = '0;
        bus.Cmd_Imm = '0;
        for (int i = 0; i < 8; i++) mdl[i] = 0;
        repeat (2) @(negedge CLK);
        check("rst_ready", bus.Cmd_Ready, 1);
        check("rst_we", bus.RF_Write_Enable, 0);
        check("rst_done", bus.Done, 0);
        check("rst_result", bus.Result, 0);
        check("rst_data", bus.RF_Data, 0);
        check("rst_sel0", bus.RF_Source_Select_0, 0);
        check("rst_dest", bus.RF_Destination_Select, 0);
        Reset = 1'b0;
        @(negedge CLK);
        issue(2'd0, 3'd3, 3'd0, 3'd0, 4'hA, 1, acc);
        issue(2'd1, 3'd5, 3'd3, 3'd0, 4'h0, 1, acc);
        idle(1);
        issue(2'd0, 3'd1, 3'd0, 3'd0, 4'd7, 1, acc);
        issue(2'd0, 3'd2, 3'd0, 3'd0, 4'd12, 1, acc);
        issue(2'd2, 3'd0, 3'd1, 3'd2, 4'h0, 1, acc);
        issue(2'd0, 3'd1, 3'd0, 3'd0, 4'd3, 1, acc);
        issue(2'd0, 3'd2, 3'd0, 3'd0, 4'd5, 1, acc);
        issue(2'd3, 3'd4, 3'd1, 3'd2, 4'h0, 1, acc);
        issue(2'd3, 3'd6, 3'd2, 3'd2, 4'h0, 1, acc);
        issue(2'd0, 3'd1, 3'd0, 3'd0, 4'd6, 1, acc);
        issue(2'd2, 3'd1, 3'd1, 3'd1, 4'h0, 1, acc);
        issue(2'd0, 3'd7, 3'd0, 3'd0, 4'd2, 1, acc);
        idle(6);
        check("rf_r0_add", rf[0], 3);
        check("rf_r4_sub", rf[4], 14);
        check("rf_r1_self", rf[1], 12);
        issue(2'd0, 3'd7, 3'd0, 3'd0, 4'hF, 0, acc);
        bus.Cmd_Valid = 1'b0;
        @(posedge CLK);
        #2 Reset = 1'b1;
        #1 check("abort_we", bus.RF_Write_Enable, 0);
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        check("abort_ready", bus.Cmd_Ready, 1);
        repeat (4) @(negedge CLK);
        check("abort_r7", rf[7], mdl[7]);
        d0 = done_cnt;
        issue(2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 3'($urandom), 4'($urandom), 1, prev);
        for (int i = 0; i < 3; i++) begin
            issue(2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 3'($urandom), 4'($urandom), 1, acc);
            check("b2b_spacing", acc - prev, 4);
            prev = acc;
        end
        idle(8);
        check("b2b_done_count", done_cnt - d0, 4);
        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 3'($urandom), 4'($urandom), 1, acc);
            idle($urandom_range(0, 3));
        end
        idle(1);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge CLK);
        idle(2);
        check("drain", q.size(), 0);
        for (int i = 0; i < 8; i++) check("rf_final", rf[i], mdl[i]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
